// File: rtl/pll_reset_sequencer.sv
// PLL reset pulsing, lock qualification, and game-core reset / clock-enable generation.
// Optional macro PLL_RESET_SEQ_CEN_PAUSE_EN: the pause input freezes the divider and masks enables in RUN.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       pause,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       cen_12,
  output logic       cen_6,
  output logic       cen_6b,
  output logic       cen_1p5,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    S_PLLRST = 2'd0,
    S_WAIT   = 2'd1,
    S_STAB   = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [5:0]       DIV_LAST  = 6'd39;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       div_q, div_d;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q;
  logic             locked_s_q;
  logic             hold_div;
  logic             run;
  logic             cen_ok;

`ifdef PLL_RESET_SEQ_CEN_PAUSE_EN
  assign hold_div = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold_div     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PLLRST;
      cnt_q      <= '0;
      div_q      <= '0;
      loss_q     <= '0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      loss_q     <= loss_d;
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    loss_d  = loss_q;
    cnt_d   = '0;
    div_d   = '0;

    unique case (state_q)
      S_PLLRST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (locked_s_q)             state_d = S_STAB;
        else if (cnt_q == TMO_LAST) state_d = S_PLLRST;
      end
      S_STAB: begin
        // A lock drop on the final qualification cycle still wins.
        if (!locked_s_q)             state_d = S_WAIT;
        else if (cnt_q == STAB_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!locked_s_q) begin
          state_d = S_PLLRST;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: state_d = S_PLLRST;
    endcase

    if (state_d == state_q && state_q != S_RUN) cnt_d = cnt_q + CNT_ONE;

    // Divider only advances while staying in RUN; any exit restarts at phase 0.
    if (state_q == S_RUN && state_d == S_RUN) begin
      if (hold_div)              div_d = div_q;
      else if (div_q == DIV_LAST) div_d = '0;
      else                        div_d = div_q + 6'd1;
    end
  end

  assign run           = (state_q == S_RUN);
  assign cen_ok        = run & ~hold_div;
  assign pll_rst       = (state_q == S_PLLRST);
  assign core_rst      = ~run;
  assign cen_12        = cen_ok & ((div_q % 6'd5) == 6'd0);
  assign cen_6         = cen_ok & ((div_q % 6'd10) == 6'd0);
  assign cen_6b        = cen_ok & ((div_q % 6'd10) == 6'd5);
  assign cen_1p5       = cen_ok & (div_q == 6'd0);
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: streak/countdown reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;
  localparam int PRC = 4;
  localparam int STC = 8;
  localparam int LTO = 100;
`ifdef PLL_RESET_SEQ_CEN_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pause = 1'b0;
  logic       pll_rst, core_rst, cen_12, cen_6, cen_6b, cen_1p5;
  logic [7:0] lock_loss_cnt;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .STABLE_CYCLES (STC),
    .LOCK_TIMEOUT  (LTO),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pause        (pause),
    .pll_rst      (pll_rst),
    .core_rst     (core_rst),
    .cen_12       (cen_12),
    .cen_6        (cen_6),
    .cen_6b       (cen_6b),
    .cen_1p5      (cen_1p5),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a PLL-reset countdown, a count of unlocked waiting cycles,
  // a streak of consecutive synchronized-lock samples, and the enable phase while running.
  bit m_valid = 1'b0;
  bit hist[$];
  int pulse_left, waited, streak, age, loss;
  bit running;

  logic       o_pll_rst, o_core_rst, o_cen_12, o_cen_6, o_cen_6b, o_cen_1p5;
  logic [7:0] o_loss;
  bit         e_pll_rst, e_core_rst, e_cen_12, e_cen_6, e_cen_6b, e_cen_1p5;
  int         e_phase;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit r, input bit lk, input bit pz);
    bit ls, paused;
    if (r) begin
      hist.delete();
      pulse_left = PRC; waited = 0; streak = 0; age = 0; loss = 0;
      running = 1'b0; m_valid = 1'b1;
      return;
    end
    ls     = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    paused = PAUSE_EN && running && pz;
    if (pulse_left > 0) begin
      pulse_left--;
      if (pulse_left == 0) begin waited = 0; streak = 0; end
    end else if (running) begin
      if (!ls) begin
        running = 1'b0; pulse_left = PRC;
        if (loss < 255) loss++;
      end else if (!paused) begin
        age = (age + 1) % 40;
      end
    end else if (ls) begin
      streak++;
      if (streak == STC + 1) begin running = 1'b1; age = 0; streak = 0; end
    end else if (streak > 0) begin
      streak = 0; waited = 0;
    end else begin
      waited++;
      if (waited == LTO) pulse_left = PRC;
    end
    hist.push_back(lk);
    if (hist.size() > 2) hist.delete(0);
  endtask

  task automatic step(input bit lk, input bit pz, input bit r);
    bit paused;
    @(negedge clk);
    pll_locked = lk; pause = pz; rst = r;
    #1;
    o_pll_rst = pll_rst; o_core_rst = core_rst; o_cen_12 = cen_12;
    o_cen_6 = cen_6; o_cen_6b = cen_6b; o_cen_1p5 = cen_1p5; o_loss = lock_loss_cnt;
    paused     = PAUSE_EN && running && pz;
    e_phase    = age % 40;
    e_pll_rst  = (pulse_left > 0);
    e_core_rst = !running;
    e_cen_12   = running && !paused && (e_phase % 5 == 0);
    e_cen_6    = running && !paused && (e_phase % 10 == 0);
    e_cen_6b   = running && !paused && (e_phase % 10 == 5);
    e_cen_1p5  = running && !paused && (e_phase == 0);
    if (m_valid) begin
      chk("pll_rst", o_pll_rst, e_pll_rst);
      chk("core_rst", o_core_rst, e_core_rst);
      chk("cen_12", o_cen_12, e_cen_12);
      chk("cen_6", o_cen_6, e_cen_6);
      chk("cen_6b", o_cen_6b, e_cen_6b);
      chk("cen_1p5", o_cen_1p5, e_cen_1p5);
      chk("lock_loss_cnt", o_loss, loss);
    end
    @(posedge clk);
    model_edge(r, lk, pz);
    cyc++;
  endtask

  task automatic do_reset(input bit lk);
    repeat (3) step(lk, 1'b0, 1'b1);
  endtask

  initial begin
    int n12, n6, n6b, n1p5, nboth, k, hi, to, first_rel, rise1, rise2, nhigh, nlow;
    bit got, prev;

    // Power-up with lock present: reset pulse, qualification, then 80 RUN cycles.
    do_reset(1'b1);
    n12 = 0; n6 = 0; n6b = 0; n1p5 = 0; nboth = 0;
    for (int i = 0; i < 93; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        chk("t1_reset_core_rst", o_core_rst, 1);
        chk("t1_reset_loss", o_loss, 0);
        chk("t1_reset_cen", {o_cen_12, o_cen_6, o_cen_6b, o_cen_1p5}, 0);
      end
      if (i < 4)   chk("t1_pll_rst_hi", o_pll_rst, 1);
      if (i == 4)  chk("t1_pll_rst_lo", o_pll_rst, 0);
      if (i == 12) chk("t1_core_rst_c12", o_core_rst, 1);
      if (i == 13) begin
        chk("t1_core_rst_c13", o_core_rst, 0);
        chk("t1_model_core_rst_c13", e_core_rst, 0);
        chk("t2_first_run_cens", {o_cen_12, o_cen_6, o_cen_6b, o_cen_1p5}, 4'b1101);
      end
      if (i >= 13) begin
        n12 += o_cen_12; n6 += o_cen_6; n6b += o_cen_6b; n1p5 += o_cen_1p5;
        nboth += (o_cen_6 & o_cen_6b);
      end
    end
    chk("t2_cen_12_count", n12, 16);
    chk("t2_cen_6_count", n6, 8);
    chk("t2_cen_6b_count", n6b, 8);
    chk("t2_cen_1p5_count", n1p5, 2);
    chk("t2_cen_6_6b_overlap", nboth, 0);

    // Lock loss in RUN.
    step(1'b0, 1'b0, 1'b0);
    k = 0; got = 1'b0;
    for (int j = 1; j <= 10 && !got; j++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_core_rst) begin
        got = 1'b1; k = j;
        chk("t4_cen_off", {o_cen_12, o_cen_6, o_cen_6b, o_cen_1p5}, 0);
      end
    end
    chk("t4_core_rst_delay", k, 3);
    hi = 1; got = 1'b0;
    for (int j = 0; j < 20 && !got; j++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_pll_rst) hi++; else got = 1'b1;
    end
    chk("t4_pll_rst_len", hi, 4);
    chk("t4_loss_1", o_loss, 1);
    to = 0;
    for (int n = 0; n < 300; n++) begin
      got = 1'b0;
      for (int j = 0; j < 60 && !got; j++) begin
        step(1'b1, 1'b0, 1'b0);
        if (!o_core_rst) got = 1'b1;
      end
      if (!got) to++;
      got = 1'b0;
      for (int j = 0; j < 10 && !got; j++) begin
        step(1'b0, 1'b0, 1'b0);
        if (o_core_rst) got = 1'b1;
      end
      if (!got) to++;
      if (n == 252) chk("t4_loss_254", o_loss, 254);
    end
    chk("t4_relock_timeouts", to, 0);
    chk("t4_loss_saturated", o_loss, 255);

    // Mid-sequence reset clears the loss counter.
    do_reset(1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("t4_loss_cleared", o_loss, 0);

    // Lock glitch during qualification restarts it.
    do_reset(1'b1);
    first_rel = -1;
    for (int i = 0; i < 30; i++) begin
      step(!(i >= 7 && i <= 9), 1'b0, 1'b0);
      if (!o_core_rst && first_rel < 0) first_rel = i;
    end
    chk("t3_release_cycle", first_rel, 21);

    // Lock drop on the last qualification cycle wins.
    do_reset(1'b1);
    first_rel = -1;
    for (int i = 0; i < 30; i++) begin
      step(i != 10, 1'b0, 1'b0);
      if (!o_core_rst && first_rel < 0) first_rel = i;
    end
    chk("t3_collision_release", first_rel, 22);

    // No lock at all: periodic PLL reset pulses.
    do_reset(1'b0);
    rise1 = -1; rise2 = -1; nhigh = 0; nlow = 0; prev = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_pll_rst && !prev) begin
        if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i;
      end
      prev = o_pll_rst;
      nhigh += o_pll_rst;
      nlow  += !o_core_rst;
    end
    chk("t5_first_rise", rise1, 104);
    chk("t5_period", rise2 - rise1, 104);
    chk("t5_high_cycles", nhigh, 16);
    chk("t5_core_never_released", nlow, 0);

`ifdef PLL_RESET_SEQ_CEN_PAUSE_EN
    do_reset(1'b1);
    got = 1'b0;
    for (int j = 0; j < 60 && !got; j++) begin
      step(1'b1, 1'b0, 1'b0);
      if (!o_core_rst && running && age == 3) got = 1'b1;
    end
    chk("t6_reached_phase3", got, 1);
    nhigh = 0;
    for (int j = 0; j < 7; j++) begin
      step(1'b1, 1'b1, 1'b0);
      nhigh += o_cen_12 + o_cen_6 + o_cen_6b + o_cen_1p5;
    end
    chk("t6_no_cen_in_pause", nhigh, 0);
    k = -1;
    for (int j = 0; j < 8 && k < 0; j++) begin
      step(1'b1, 1'b0, 1'b0);
      if (o_cen_12) begin k = j; chk("t6_model_phase", e_phase, 5); end
    end
    chk("t6_cen_12_after_release", k, 2);
`endif

    // Randomized lock segments, pause and occasional reset.
    do_reset(1'b1);
    for (int s = 0; s < 400 && cyc < 20000; s++) begin
      bit lk;
      int len;
      lk  = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 160) : $urandom_range(1, 20);
      for (int j = 0; j < len; j++)
        step(lk, $urandom_range(0, 7) == 0, $urandom_range(0, 999) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system PLL wrapper, in the 60 MHz core clock domain (PLL output 0).
- Consumes the PLL `locked` flag and drives the PLL reset input back.
- Sequences core reset release only after lock has been stable for a set time.
- Generates the game-core clock enables: 12, 6 (two phases) and 1.5 MHz.
- Recovers automatically from lock loss or lock timeout by re-pulsing PLL reset.

Parameters:
- PLL_RST_CYCLES, 16, cycles `pll_rst` is held high per PLL reset pulse (≥1).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before core reset release (≥1).
- LOCK_TIMEOUT, 1048576, cycles waited in WAIT without lock before re-resetting the PLL (≥2).
- CNT_W, 21, shared state counter width; must hold max(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT).

Ports:
- clk  in  1  60 MHz core clock (PLL outclk_0).
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock flag; asynchronous to clk.
- pause  in  1  freeze clock enables (only with CEN_PAUSE_EN).
- pll_rst  out  1  reset to PLL.
- core_rst  out  1  active-high reset to game core.
- cen_12  out  1  12 MHz enable, 1-in-5.
- cen_6  out  1  6 MHz enable, phase A.
- cen_6b  out  1  6 MHz enable, phase B (offset 5 cycles).
- cen_1p5  out  1  1.5 MHz enable, 1-in-40.
- lock_loss_cnt  out  8  saturating count of lock losses seen in RUN.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.

Lock synchronizer:
- `pll_locked` passes through a 2-FF synchronizer to give `locked_s` (2-cycle latency).
- Both FFs reset to 0.

Reset values:
- state = PLLRST, counter = 0, div_cnt = 0, lock_loss_cnt = 0.
- pll_rst = 1, core_rst = 1, all cen_* = 0.

FSM (registered; the counter clears on every state change):
- PLLRST: pll_rst = 1. When counter = PLL_RST_CYCLES-1, go to WAIT.
- WAIT:
  - locked_s = 1 → STAB.
  - Otherwise counter increments; at counter = LOCK_TIMEOUT-1 → PLLRST.
- STAB:
  - locked_s = 0 → WAIT (glitch restarts qualification).
  - At counter = STABLE_CYCLES-1 → RUN.
- RUN:
  - locked_s = 0 → PLLRST.
  - On that transition lock_loss_cnt increments, saturating at 255.

Output decode (from registers only, no input-to-output combinational path):
- pll_rst = (state == PLLRST).
- core_rst = (state != RUN); it falls on the first RUN cycle and rises on the first PLLRST cycle after lock loss.

Divider:
- div_cnt runs 0..39, incrementing each RUN cycle and wrapping 39 → 0; held at 0 outside RUN.
- All enables are forced to 0 outside RUN.
- cen_12 = RUN & (div_cnt mod 5 == 0).
- cen_6 = RUN & (div_cnt mod 10 == 0).
- cen_6b = RUN & (div_cnt mod 10 == 5).
- cen_1p5 = RUN & (div_cnt == 0).
- Consequence: the first RUN cycle asserts cen_12, cen_6 and cen_1p5 together; cen_6 and cen_6b never coincide.

Boundary conditions:
- rst mid-sequence returns to PLLRST from any state and clears lock_loss_cnt.
- Lock loss on the same cycle STAB completes: locked_s = 0 takes priority and the FSM goes to WAIT.

Optional Feature:
- Macro: PLL_RESET_SEQ_CEN_PAUSE_EN.
- Defined:
  - pause = 1 in RUN holds div_cnt and forces all cen_* to 0.
  - Release resumes from the held phase, with no phase skip.
  - core_rst and the FSM are unaffected.
- Undefined: the `pause` port exists but is ignored.

Test Plan (PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=100):
1. Hold rst for 3 cycles, pll_locked = 1 constant → pll_rst high on cycles 0-3 after release; core_rst = 0 from cycle 13 onward.
2. Run 80 cycles in RUN → per 40 cycles: 8 cen_12 pulses at phases 0,5,…,35; cen_6 at 0,10,20,30; cen_6b at 5,15,25,35; exactly one cen_1p5 at phase 0.
3. pll_locked low for 3 cycles mid-STAB → FSM to WAIT then STAB again; core_rst stays 1 until a full 8 stable cycles complete.
4. pll_locked falls in RUN → core_rst = 1 and cen_* = 0 on the 3rd cycle after the fall; pll_rst high 4 cycles; lock_loss_cnt 0 → 1. Repeat 300 times → saturates at 255.
5. pll_locked held 0 → pll_rst pulses 4 cycles every 104 cycles indefinitely; core_rst never falls.
6. With the macro defined, pause = 1 for 7 cycles starting at div_cnt = 3 → no cen_* pulses during pause; the next cen_12 arrives 2 cycles after pause drops, at phase 5.
